// File: rtl/decoder_ctrl_pkg.sv
// decoder_ctrl_pkg: shared constants for the input-side bus decoder.
// Opcodes, segment types, header field positions and FSM encoding.
package decoder_ctrl_pkg;

    localparam int BUS_SIZE   = 32;
    localparam int BLCK_SIZE  = 256;
    localparam int BLCKdivBUS = BLCK_SIZE / BUS_SIZE;

    // Instruction opcodes (carried in the top nibble of the word)
    localparam logic [3:0] OP_LDKEY = 4'h1;
    localparam logic [3:0] OP_ENC   = 4'h2;
    localparam logic [3:0] OP_DEC   = 4'h3;

    // Segment types
    localparam logic [3:0] SEG_AD  = 4'h1;
    localparam logic [3:0] SEG_PT  = 4'h4;
    localparam logic [3:0] SEG_CT  = 4'h5;
    localparam logic [3:0] SEG_TAG = 4'h8;

    // Header field positions
    localparam int HDR_TYPE_MSB = 31;
    localparam int HDR_TYPE_LSB = 28;
    localparam int HDR_EOI_BIT  = 26;
    localparam int HDR_LAST_BIT = 24;
    localparam int HDR_LEN_MSB  = 15;

    typedef enum logic [1:0] {
        S_INSTR = 2'd0,
        S_HDR   = 2'd1,
        S_DATA  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/decoder_ctrl_len_cnt.sv
// decoder_len_cnt: remaining-bytes counter for the current segment.
// Reports bytes taken by the next word and whether that word is the last.
module decoder_len_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        dec_i,
    output logic [2:0]  take_o,
    output logic        last_o,
    output logic        zero_o
);

    logic [15:0] rem_q;
    logic [15:0] rem_d;

    // Bytes consumed by one word: min(remaining, 4)
    always_comb begin
        take_o = (rem_q >= 16'd4) ? 3'd4 : rem_q[2:0];
        last_o = (rem_q <= 16'd4);
        zero_o = (rem_q == 16'd0);
        rem_d  = rem_q;
        if (load_i)
            rem_d = load_val_i;
        else if (dec_i)
            rem_d = rem_q - {13'd0, take_o};
    end

    // Remaining-bytes register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rem_q <= 16'd0;
        else
            rem_q <= rem_d;
    end

endmodule

// File: rtl/decoder_ctrl.sv
// decoder_ctrl: parses instruction/header words and steers data words
// into the block register, handing finished blocks to the mode core.
module decoder_ctrl
    import decoder_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [BUS_SIZE-1:0] data_in,
    input  logic                data_in_valid,
    output logic                data_in_ready,
    output logic                instr_valid,
    output logic [3:0]          instr_opcode,
    output logic                seg_valid,
    output logic [3:0]          seg_type,
    output logic                seg_eoi,
    output logic                seg_last,
    output logic [2:0]          ctrl_word_idx,
    output logic                ctrl_word_we,
    output logic [2:0]          ctrl_word_bytes,
    output logic                ctrl_blck_clr,
    output logic                block_valid,
    input  logic                block_ready,
    output logic [5:0]          block_bytes,
    output logic                block_last
);

    state_t      state_q;
    logic        instr_valid_q;
    logic [3:0]  opcode_q;
    logic        seg_valid_q;
    logic [3:0]  seg_type_q;
    logic        seg_eoi_q;
    logic        seg_last_q;
    logic [2:0]  word_q;
    logic [2:0]  word_d;
    logic [5:0]  byte_q;
    logic [5:0]  byte_d;
    logic        blk_valid_q;
    logic [5:0]  blk_bytes_q;
    logic        blk_last_q;

    logic        accept;
    logic        in_data;
    logic        hdr_load;
    logic [2:0]  take;
    logic        len_last;
    logic        len_zero;
    logic        release_blk;
    logic        unused_hdr;

    assign unused_hdr = ^{data_in[27], data_in[25], data_in[23:16]};

    assign data_in_ready = (state_q != S_HOLD);
    assign accept        = data_in_valid & data_in_ready;
    assign in_data       = (state_q == S_DATA);
    assign hdr_load      = accept & (state_q == S_HDR);
    assign release_blk   = (state_q == S_HOLD) & blk_valid_q & block_ready;

    decoder_len_cnt u_len (
        .clk        (clk),
        .rst        (rst),
        .load_i     (hdr_load),
        .load_val_i (data_in[HDR_LEN_MSB:0]),
        .dec_i      (accept & in_data),
        .take_o     (take),
        .last_o     (len_last),
        .zero_o     (len_zero)
    );

    // Same-cycle write strobe into the block register
    always_comb begin
        ctrl_word_we    = accept & in_data;
        ctrl_word_idx   = word_q;
        ctrl_word_bytes = in_data ? take : 3'd0;
        ctrl_blck_clr   = release_blk;
        word_d          = word_q + 3'd1;
        byte_d          = byte_q + {3'd0, take};
    end

    // Parser FSM with registered pulses, fields and block handoff
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_INSTR;
            instr_valid_q <= 1'b0;
            opcode_q      <= 4'd0;
            seg_valid_q   <= 1'b0;
            seg_type_q    <= 4'd0;
            seg_eoi_q     <= 1'b0;
            seg_last_q    <= 1'b0;
            word_q        <= 3'd0;
            byte_q        <= 6'd0;
            blk_valid_q   <= 1'b0;
            blk_bytes_q   <= 6'd0;
            blk_last_q    <= 1'b0;
        end else begin
            instr_valid_q <= 1'b0;
            seg_valid_q   <= 1'b0;
            unique case (state_q)
                S_INSTR: if (accept) begin
                    opcode_q      <= data_in[HDR_TYPE_MSB:HDR_TYPE_LSB];
                    instr_valid_q <= 1'b1;
                    state_q       <= S_HDR;
                end
                S_HDR: if (accept) begin
                    seg_type_q  <= data_in[HDR_TYPE_MSB:HDR_TYPE_LSB];
                    seg_eoi_q   <= data_in[HDR_EOI_BIT];
                    seg_last_q  <= data_in[HDR_LAST_BIT];
                    seg_valid_q <= 1'b1;
                    if (data_in[HDR_LEN_MSB:0] == 16'd0) begin
                        blk_valid_q <= 1'b1;
                        blk_bytes_q <= 6'd0;
                        blk_last_q  <= 1'b1;
                        state_q     <= S_HOLD;
                    end else begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: if (accept) begin
                    word_q <= word_d;
                    byte_q <= byte_d;
                    if (word_q == 3'(BLCKdivBUS - 1) || len_last) begin
                        blk_valid_q <= 1'b1;
                        blk_bytes_q <= byte_d;
                        blk_last_q  <= len_last;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: if (release_blk) begin
                    blk_valid_q <= 1'b0;
                    word_q      <= 3'd0;
                    byte_q      <= 6'd0;
                    if (!len_zero)
                        state_q <= S_DATA;
                    else if (seg_last_q)
                        state_q <= S_INSTR;
                    else
                        state_q <= S_HDR;
                end
                default: state_q <= S_INSTR;
            endcase
        end
    end

    assign instr_valid  = instr_valid_q;
    assign instr_opcode = opcode_q;
    assign seg_valid    = seg_valid_q;
    assign seg_type     = seg_type_q;
    assign seg_eoi      = seg_eoi_q;
    assign seg_last     = seg_last_q;
    assign block_valid  = blk_valid_q;
    assign block_bytes  = blk_bytes_q;
    assign block_last   = blk_last_q;

endmodule

// File: tb/tb_decoder_ctrl.sv
// tb_decoder_ctrl: scoreboard bench for decoder_ctrl.
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_decoder_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic        instr_valid;
    logic [3:0]  instr_opcode;
    logic        seg_valid;
    logic [3:0]  seg_type;
    logic        seg_eoi;
    logic        seg_last;
    logic [2:0]  ctrl_word_idx;
    logic        ctrl_word_we;
    logic [2:0]  ctrl_word_bytes;
    logic        ctrl_blck_clr;
    logic        block_valid;
    logic        block_ready;
    logic [5:0]  block_bytes;
    logic        block_last;

    int checks = 0;
    int errors = 0;

    logic [3:0] q_instr[$];
    logic [5:0] q_seg[$];
    logic [5:0] q_word[$];
    logic [6:0] q_blk[$];

    decoder_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .data_in         (data_in),
        .data_in_valid   (data_in_valid),
        .data_in_ready   (data_in_ready),
        .instr_valid     (instr_valid),
        .instr_opcode    (instr_opcode),
        .seg_valid       (seg_valid),
        .seg_type        (seg_type),
        .seg_eoi         (seg_eoi),
        .seg_last        (seg_last),
        .ctrl_word_idx   (ctrl_word_idx),
        .ctrl_word_we    (ctrl_word_we),
        .ctrl_word_bytes (ctrl_word_bytes),
        .ctrl_blck_clr   (ctrl_blck_clr),
        .block_valid     (block_valid),
        .block_ready     (block_ready),
        .block_bytes     (block_bytes),
        .block_last      (block_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event, got 1 expected 0", name);
    endtask

    // Monitor: compare every DUT event against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid) begin
                if (q_instr.size() == 0) unexpected("instr");
                else chk("instr_opcode", 32'(instr_opcode),
                         32'(q_instr.pop_front()));
            end
            if (seg_valid) begin
                if (q_seg.size() == 0) unexpected("seg");
                else chk("seg_fields", 32'({seg_type, seg_eoi, seg_last}),
                         32'(q_seg.pop_front()));
            end
            if (ctrl_word_we) begin
                if (q_word.size() == 0) unexpected("word");
                else chk("word_idx_bytes",
                         32'({ctrl_word_idx, ctrl_word_bytes}),
                         32'(q_word.pop_front()));
            end
            if (block_valid && block_ready) begin
                if (q_blk.size() == 0) unexpected("block");
                else begin
                    chk("block_bytes_last", 32'({block_bytes, block_last}),
                        32'(q_blk.pop_front()));
                    chk("blck_clr", 32'(ctrl_blck_clr), 32'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        logic r;
        int   n;
        data_in       = w;
        data_in_valid = 1'b1;
        n = 0;
        forever begin
            r = data_in_ready;
            tick();
            if (r) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        data_in_valid = 1'b0;
    endtask

    task automatic words(input int start, input int nfull,
                         input logic [2:0] tail);
        for (int i = 0; i < nfull; i++) begin
            q_word.push_back({3'(start + i), 3'd4});
            send(32'hA5A5_0000 + 32'(i));
        end
        if (tail != 3'd0) begin
            q_word.push_back({3'(start + nfull), tail});
            send(32'h5A5A_0000);
        end
    endtask

    initial begin
        rst           = 1'b1;
        data_in       = 32'd0;
        data_in_valid = 1'b0;
        block_ready   = 1'b1;
        tick();
        chk("rst_ready", 32'(data_in_ready), 32'd1);
        chk("rst_outs", 32'({instr_valid, instr_opcode, seg_valid, seg_type,
                             seg_eoi, seg_last, ctrl_word_we, ctrl_blck_clr,
                             block_valid, block_bytes, block_last}), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Instr 0x2, header type 1 last 1 len 32, one full block
        q_instr.push_back(4'h2);
        send(32'h2000_0000);
        q_seg.push_back({4'h1, 1'b0, 1'b1});
        q_blk.push_back({6'd32, 1'b1});
        send(32'h1100_0020);
        words(0, 8, 3'd0);

        // Back in S_INSTR: instr 0x3, header len 33 eoi 1 last 1
        q_instr.push_back(4'h3);
        send(32'h3000_0000);
        q_seg.push_back({4'h1, 1'b1, 1'b1});
        q_blk.push_back({6'd32, 1'b0});
        q_blk.push_back({6'd1, 1'b1});
        send(32'h1500_0021);
        words(0, 8, 3'd0);
        words(0, 0, 3'd1);

        // Zero-length header, last 0: block next cycle, then header again
        q_instr.push_back(4'h2);
        send(32'h2000_0000);
        q_seg.push_back({4'h4, 1'b0, 1'b0});
        q_blk.push_back({6'd0, 1'b1});
        send(32'h4000_0000);
        chk("len0_valid", 32'(block_valid), 32'd1);
        chk("len0_ready", 32'(data_in_ready), 32'd0);
        q_seg.push_back({4'h5, 1'b0, 1'b1});
        q_blk.push_back({6'd5, 1'b1});
        send(32'h5100_0005);
        words(0, 1, 3'd1);

        // Full block with the core stalling for 5 cycles
        q_instr.push_back(4'h2);
        send(32'h2000_0000);
        q_seg.push_back({4'h1, 1'b0, 1'b1});
        send(32'h1100_0020);
        block_ready = 1'b0;
        words(0, 8, 3'd0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_ready", 32'(data_in_ready), 32'd0);
            chk("stall_fields", 32'({block_valid, block_bytes, block_last}),
                32'({1'b1, 6'd32, 1'b1}));
            tick();
        end
        q_blk.push_back({6'd32, 1'b1});
        block_ready = 1'b1;
        tick();
        chk("stall_released", 32'({data_in_ready, block_valid}), 32'b10);

        // Reset after 3 data words of a 64-byte segment
        q_instr.push_back(4'h2);
        send(32'h2000_0000);
        q_seg.push_back({4'h1, 1'b0, 1'b1});
        send(32'h1100_0040);
        words(0, 3, 3'd0);
        rst = 1'b1;
        #1;
        chk("midrst_outs", 32'({instr_valid, instr_opcode, seg_valid,
                                seg_type, seg_eoi, seg_last, ctrl_word_we,
                                ctrl_word_idx, block_valid, block_bytes,
                                block_last}), 32'd0);
        chk("midrst_ready", 32'(data_in_ready), 32'd1);
        #1;
        rst = 1'b0;
        tick();
        q_instr.push_back(4'h7);
        send(32'h7000_0000);
        q_seg.push_back({4'h8, 1'b0, 1'b1});
        q_blk.push_back({6'd2, 1'b1});
        send(32'h8100_0002);
        words(0, 0, 3'd2);

        for (int i = 0; i < 4; i++) tick();
        chk("q_instr_empty", 32'(q_instr.size()), 32'd0);
        chk("q_seg_empty", 32'(q_seg.size()), 32'd0);
        chk("q_word_empty", 32'(q_word.size()), 32'd0);
        chk("q_blk_empty", 32'(q_blk.size()), 32'd0);
        chk("end_ready", 32'(data_in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
